snake_move_ctrl: RTL
====================

# snake_move_ctrl

Movement sequencer for the SNAKE game. It samples the one-hot heading from the direction logic on each game tick and advances the snake head on a bounded grid. It keeps every body segment in a circular position buffer and detects wall and self collisions. Its outputs drive the VGA/LED renderer and the score logic.

## Interface
- GRID_W, 32: grid width in cells; x range 0..GRID_W-1
- GRID_H, 24: grid height in cells; y range 0..GRID_H-1
- MAX_LEN, 64: maximum snake length and buffer depth; power of two
- TICK_DIV, 25_000_000: clocks per game tick; must be ≥ MAX_LEN+4
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; starts a game from IDLE and restarts from DEAD
- heading  in  4  one-hot direction: 0001 up (y−1), 0010 right (x+1), 0100 down (y+1), 1000 left (x−1)
- grow_req  in  1  pulse; grow by one segment at the next commit
- head_x / head_y  out  $clog2(GRID_W) / $clog2(GRID_H)  current head cell
- length  out  $clog2(MAX_LEN)+1  current segment count
- step_done  out  1  one-cycle pulse when a move commits
- game_over  out  1  high while in DEAD
- rd_idx  in  $clog2(MAX_LEN)  renderer segment index; 0 is the head
- rd_x / rd_y  out  coord widths  position of segment rd_idx, registered
- rd_valid  out  1  registered flag, rd_idx < length

## Operation
- FSM states:
  - IDLE → RUN on start.
  - RUN → MOVE on tick.
  - MOVE → CHECK, or → DEAD on wall hit.
  - CHECK → COMMIT when the scan is clean, or → DEAD on a match.
  - COMMIT → RUN.
  - DEAD → INIT on start.
  - INIT → RUN. INIT reinitialises head, length and buffer, like reset.
- Reset values:
  - State IDLE.
  - head = (GRID_W/2, GRID_H/2).
  - length = 1.
  - Buffer entry 0 = head, head pointer hp = 0.
  - step_done = 0, game_over = 0, rd_x/rd_y = 0, rd_valid = 0.
  - Tick counter = 0.
  - Grow-pending flag = 0, last direction = right.
- Tick counter:
  - Counts only in RUN..COMMIT and clears in IDLE, INIT and DEAD.
  - A tick is generated when the count reaches TICK_DIV-1, then the count wraps to 0.
- MOVE:
  - Latch heading if it is one-hot and, when length > 1, not the reverse of the last direction.
  - Otherwise keep the last direction.
  - Compute the candidate head.
  - Leaving the grid (x or y below 0, or ≥ GRID_W/GRID_H) is a wall hit; no wrap-around.
- CHECK:
  - Compare the candidate against segments 1..N−1, one segment per clock.
  - N = length+1 if a grow is pending (saturating at MAX_LEN), else length; the tail vacates when not growing.
  - length = 1 skips the scan (zero cycles).
- COMMIT:
  - hp ← hp+1 mod MAX_LEN; write the candidate at the new hp.
  - If a grow is pending and length < MAX_LEN, length+1; clear the grow flag.
  - Pulse step_done.
- Segment k is stored at (hp−k) mod MAX_LEN.
- grow_req in any state except IDLE/DEAD sets the grow flag. Multiple requests before one commit collapse to one.
- DEAD: head, length and the buffer are frozen; only start leaves DEAD.
- start while RUN..COMMIT is ignored.

## Timing
- A move takes the tick cycle plus 3 cycles (MOVE, CHECK entry, COMMIT) plus max(N−1,0) scan cycles. A move is always finished before the next tick.
- head_x/head_y and length update on the clock edge that ends COMMIT, in the same cycle step_done is high.
- game_over rises one cycle after the failing MOVE or CHECK cycle. head is not updated on a collision.
- Read port latency is 1 clock; it is independent of the FSM and valid in all states.
- Reset is asynchronous: mid-move it aborts immediately, and all outputs return to their reset values.

## Structure
- snake_pkg holds the heading one-hot constants, the reverse-direction function, the FSM state enum, and the coordinate width localparams.
- Sub-module snake_seg_buf holds MAX_LEN×(x,y) registers with one write port and two read ports (scan read combinational, render read registered).

## Test plan
- Reset with TICK_DIV=8, no start → head (16,12), length 1, game_over 0, no step_done over 100 cycles.
- start, heading 0010, 3 ticks → head (19,12), exactly 3 step_done pulses, 8 clocks apart.
- start with heading 0010, 2 grow_req pulses in separate tick windows, 3 ticks → length 3. rd_idx 0/1/2 → (19,12), (18,12), (17,12), rd_valid 1. rd_idx 3 → rd_valid 0.
- Drive the head to y=0 with heading 0001, then one more tick → game_over 1, head stays (x,0), length unchanged. start → head (16,12), length 1, RUN.
- length 5, headings 0010, 0100, 1000, 0001 on consecutive ticks → self collision, game_over 1. Reverse heading 1000 while moving right with length > 1 → ignored, head moves right.
- Assert rst_n low during CHECK → all outputs equal reset values within the same cycle, state IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared constants, FSM state type and helpers for the snake movement sequencer.
//   Heading one-hot codes, default grid geometry, coordinate/index widths,
//   FSM state enum and the reverse-direction function.
package snake_pkg;
    localparam logic [3:0] H_UP    = 4'b0001;
    localparam logic [3:0] H_RIGHT = 4'b0010;
    localparam logic [3:0] H_DOWN  = 4'b0100;
    localparam logic [3:0] H_LEFT  = 4'b1000;

    localparam int GRID_W_DEF  = 32;
    localparam int GRID_H_DEF  = 24;
    localparam int MAX_LEN_DEF = 64;
    localparam int XW_DEF      = $clog2(GRID_W_DEF);
    localparam int YW_DEF      = $clog2(GRID_H_DEF);
    localparam int IW_DEF      = $clog2(MAX_LEN_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_MOVE,
        S_CHECK,
        S_COMMIT,
        S_DEAD,
        S_INIT
    } state_t;

    // up<->down and right<->left swap by exchanging the two bit pairs
    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        return {d[1:0], d[3:2]};
    endfunction
endpackage

// File: rtl/snake_move_ctrl_if.sv
// snake_move_ctrl_if: game-side and renderer-side signals of the movement sequencer.
//   slave  (sequencer): in start, heading, grow_req, rd_idx;
//                       out head_x, head_y, length, step_done, game_over, rd_x, rd_y, rd_valid
//   master (driver):    the mirror image
interface snake_move_ctrl_if
    import snake_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int IW = IW_DEF
);
    logic          start;
    logic [3:0]    heading;
    logic          grow_req;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [IW:0]   length;
    logic          step_done;
    logic          game_over;
    logic [IW-1:0] rd_idx;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_valid;

    modport slave (
        input  start, heading, grow_req, rd_idx,
        output head_x, head_y, length, step_done, game_over, rd_x, rd_y, rd_valid
    );

    modport master (
        output start, heading, grow_req, rd_idx,
        input  head_x, head_y, length, step_done, game_over, rd_x, rd_y, rd_valid
    );
endinterface

// File: rtl/snake_seg_buf.sv
// snake_seg_buf: circular body-segment position store.
//   clk, rst_n     clock, asynchronous active-low reset (all entries -> (X0,Y0))
//   we, wa, wx, wy single write port
//   sa -> sx, sy   combinational scan read
//   ra -> rx, ry   registered render read (1 clock latency)
module snake_seg_buf #(
    parameter int            DEPTH = 64,
    parameter int            XW    = 5,
    parameter int            YW    = 5,
    parameter logic [XW-1:0] X0    = '0,
    parameter logic [YW-1:0] Y0    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wa,
    input  logic [XW-1:0]            wx,
    input  logic [YW-1:0]            wy,
    input  logic [$clog2(DEPTH)-1:0] sa,
    output logic [XW-1:0]            sx,
    output logic [YW-1:0]            sy,
    input  logic [$clog2(DEPTH)-1:0] ra,
    output logic [XW-1:0]            rx,
    output logic [YW-1:0]            ry
);
    logic [XW-1:0] mx [DEPTH];
    logic [YW-1:0] my [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mx[i] <= X0;
                my[i] <= Y0;
            end
            rx <= '0;
            ry <= '0;
        end else begin
            if (we) begin
                mx[wa] <= wx;
                my[wa] <= wy;
            end
            rx <= mx[ra];
            ry <= my[ra];
        end
    end

    assign sx = mx[sa];
    assign sy = my[sa];
endmodule

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: tick-driven snake head sequencer with wall and self-collision detection.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus.slave   start/heading/grow_req in; head_x/head_y/length/step_done/game_over out;
//               rd_idx in, rd_x/rd_y/rd_valid out (registered renderer read port)
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int MAX_LEN  = MAX_LEN_DEF,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    snake_move_ctrl_if.slave bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [XW-1:0] X0 = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y0 = YW'(GRID_H / 2);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [XW-1:0] hx, cx, nx, wx, sx;
    logic [YW-1:0] hy, cy, ny, wy, sy;
    logic [LW-1:0] len, n_seg, idx;
    logic [IW-1:0] hp, wa, sa, ra;
    logic [3:0]    dir, dir_n;
    logic          grow, tick, busy, wall, hit, we, step_done, rd_valid;

    always_comb begin
        busy  = state inside {S_RUN, S_MOVE, S_CHECK, S_COMMIT};
        tick  = cnt == CW'(TICK_DIV - 1);
        n_seg = (grow && len < LW'(MAX_LEN)) ? len + 1'b1 : len;
        dir_n = ($onehot(bus.heading) && !(len > LW'(1) && bus.heading == reverse_dir(dir))) ? bus.heading : dir;
        wall  = (dir_n == H_UP && hy == '0) || (dir_n == H_DOWN && hy == YW'(GRID_H - 1)) ||
                (dir_n == H_LEFT && hx == '0) || (dir_n == H_RIGHT && hx == XW'(GRID_W - 1));
        nx    = dir_n == H_RIGHT ? hx + 1'b1 : dir_n == H_LEFT ? hx - 1'b1 : hx;
        ny    = dir_n == H_DOWN ? hy + 1'b1 : dir_n == H_UP ? hy - 1'b1 : hy;
        // scan step k checks the segment that becomes k after the move, i.e. current segment k-1;
        // the current tail is never read, so a non-growing snake may step into its vacating tail
        sa    = hp - IW'(idx - 1'b1);
        hit   = sx == cx && sy == cy;
        we    = state == S_COMMIT || state == S_INIT;
        wa    = state == S_INIT ? '0 : hp + 1'b1;
        wx    = state == S_INIT ? X0 : cx;
        wy    = state == S_INIT ? Y0 : cy;
        ra    = hp - bus.rd_idx;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = bus.start ? S_RUN : S_IDLE;
            S_RUN:    state_n = tick ? S_MOVE : S_RUN;
            S_MOVE:   state_n = wall ? S_DEAD : S_CHECK;
            S_CHECK:  state_n = idx >= n_seg ? S_COMMIT : hit ? S_DEAD : S_CHECK;
            S_COMMIT: state_n = S_RUN;
            S_DEAD:   state_n = bus.start ? S_INIT : S_DEAD;
            S_INIT:   state_n = S_RUN;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hx        <= X0;
            hy        <= Y0;
            cx        <= X0;
            cy        <= Y0;
            len       <= LW'(1);
            hp        <= '0;
            dir       <= H_RIGHT;
            grow      <= 1'b0;
            idx       <= LW'(1);
            step_done <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= (busy && !tick) ? cnt + 1'b1 : '0;
            idx       <= state == S_CHECK ? idx + 1'b1 : LW'(1);
            step_done <= state == S_COMMIT;
            rd_valid  <= LW'(bus.rd_idx) < len;
            // a request arriving during COMMIT is kept for the following move
            grow      <= (state == S_COMMIT || state == S_INIT) ? bus.grow_req :
                         grow | (bus.grow_req && state != S_IDLE && state != S_DEAD);
            if (state == S_MOVE) begin
                dir <= dir_n;
                cx  <= nx;
                cy  <= ny;
            end
            if (state == S_COMMIT) begin
                hx  <= cx;
                hy  <= cy;
                hp  <= hp + 1'b1;
                len <= n_seg;
            end
            if (state == S_INIT) begin
                hx  <= X0;
                hy  <= Y0;
                len <= LW'(1);
                hp  <= '0;
                dir <= H_RIGHT;
            end
        end
    end

    snake_seg_buf #(
        .DEPTH (MAX_LEN),
        .XW    (XW),
        .YW    (YW),
        .X0    (X0),
        .Y0    (Y0)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wx    (wx),
        .wy    (wy),
        .sa    (sa),
        .sx    (sx),
        .sy    (sy),
        .ra    (ra),
        .rx    (bus.rd_x),
        .ry    (bus.rd_y)
    );

    assign bus.head_x    = hx;
    assign bus.head_y    = hy;
    assign bus.length    = len;
    assign bus.step_done = step_done;
    assign bus.game_over = state == S_DEAD;
    assign bus.rd_valid  = rd_valid;
endmodule
